// File: rtl/alu_step_sequencer.sv
// Walks the control ROM step by step, fetches operand pairs, drives a registered ALU
// and emits each result on a valid/ready stream; illegal opcodes are skipped and flagged.
module alu_step_sequencer #(
    parameter int NUM_STEPS = 28,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [4:0]        ctrl_addr,
    input  logic [5:0]        ctrl_data,
    output logic [1:0]        opa_addr,
    output logic [1:0]        opb_addr,
    input  logic [DATA_W-1:0] opa_data,
    input  logic [DATA_W-1:0] opb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [4:0]        res_step,
    output logic [3:0]        res_op,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [5:0]        emit_count
);

    localparam logic [4:0] LAST_STEP = 5'(NUM_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_OPND,
        S_EXEC,
        S_EMIT,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] step;
    logic [1:0] idx;
    logic [3:0] op;
    logic       fetch_legal;
    logic       last_step;

    function automatic logic op_legal(input logic [3:0] o);
        case (o)
            4'b0001, 4'b0011, 4'b0100, 4'b1000,
            4'b1010, 4'b1101, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    assign fetch_legal = op_legal(ctrl_data[3:0]);
    assign last_step   = (step == LAST_STEP);

    // Addresses come straight from registers so the ROM path never loops through inputs.
    assign ctrl_addr = step;
    assign opa_addr  = idx;
    assign opb_addr  = idx;
    assign res_valid = (state == S_EMIT);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_FETCH;
                S_FETCH: begin
                    if (fetch_legal)    state_nxt = S_OPND;
                    else if (last_step) state_nxt = S_DONE;
                end
                S_OPND:  state_nxt = S_EXEC;
                S_EXEC:  state_nxt = S_EMIT;
                S_EMIT:  if (res_ready) state_nxt = last_step ? S_DONE : S_FETCH;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step        <= '0;
            idx         <= '0;
            op          <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            res_data    <= '0;
            res_step    <= '0;
            res_op      <= '0;
            err_illegal <= 1'b0;
            emit_count  <= '0;
        end else if (abort) begin
            // Status flags survive an abort so software can inspect the partial run.
            step <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    step <= '0;
                    if (start) begin
                        err_illegal <= 1'b0;
                        emit_count  <= '0;
                    end
                end
                S_FETCH: begin
                    idx <= ctrl_data[5:4];
                    op  <= ctrl_data[3:0];
                    if (!fetch_legal) begin
                        err_illegal <= 1'b1;
                        if (!last_step) step <= step + 5'd1;
                    end
                end
                S_OPND: begin
                    alu_a  <= opa_data;
                    alu_b  <= opb_data;
                    alu_op <= op;
                end
                S_EXEC: begin
                    res_data <= alu_result;
                    res_step <= step;
                    res_op   <= alu_op;
                end
                S_EMIT: begin
                    if (res_ready) begin
                        emit_count <= emit_count + 6'd1;
                        if (!last_step) step <= step + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Bench for alu_step_sequencer: ROM/ALU models, run-level reference model,
// spot-check vector table and hand-written backpressure/abort/reset/single-step cases.
module tb_alu_step_sequencer;
    localparam int NS = 28;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, res_ready;
    logic [4:0]  ctrl_addr;
    logic [5:0]  ctrl_data;
    logic [1:0]  opa_addr, opb_addr;
    logic [31:0] opa_data, opb_data, alu_a, alu_b, alu_result, res_data;
    logic [3:0]  alu_op, res_op;
    logic        res_valid, busy, done, err_illegal;
    logic [4:0]  res_step;
    logic [5:0]  emit_count;

    logic        start_s1, res_ready_s1;
    logic [4:0]  ctrl_addr_s1;
    logic [5:0]  ctrl_data_s1;
    logic [1:0]  opa_addr_s1, opb_addr_s1;
    logic [31:0] opa_data_s1, opb_data_s1, alu_a_s1, alu_b_s1, alu_result_s1, res_data_s1;
    logic [3:0]  alu_op_s1, res_op_s1;
    logic        res_valid_s1, busy_s1, done_s1, err_illegal_s1;
    logic [4:0]  res_step_s1;
    logic [5:0]  emit_count_s1;

    logic [31:0] rom_a [4];
    logic [31:0] rom_b [4];
    logic [5:0]  ctrl_rom [32];
    logic [3:0]  legal_ops [7];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd1:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a & b;
            4'd8:    return a | b;
            4'd10:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd13:   return ~a;
            4'd15:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'd1, 4'd3, 4'd4, 4'd8, 4'd10, 4'd13, 4'd15};
    endfunction

    assign ctrl_data     = ctrl_rom[ctrl_addr];
    assign opa_data      = rom_a[opa_addr];
    assign opb_data      = rom_b[opb_addr];
    assign alu_result    = alu_f(alu_a, alu_b, alu_op);
    assign ctrl_data_s1  = ctrl_rom[ctrl_addr_s1];
    assign opa_data_s1   = rom_a[opa_addr_s1];
    assign opb_data_s1   = rom_b[opb_addr_s1];
    assign alu_result_s1 = alu_f(alu_a_s1, alu_b_s1, alu_op_s1);

    alu_step_sequencer #(.NUM_STEPS(NS), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ctrl_addr(ctrl_addr), .ctrl_data(ctrl_data),
        .opa_addr(opa_addr), .opb_addr(opb_addr), .opa_data(opa_data), .opb_data(opb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_step(res_step), .res_op(res_op), .busy(busy), .done(done),
        .err_illegal(err_illegal), .emit_count(emit_count)
    );

    alu_step_sequencer #(.NUM_STEPS(1), .DATA_W(32)) dut_s1 (
        .clk(clk), .rst(rst), .start(start_s1), .abort(1'b0),
        .ctrl_addr(ctrl_addr_s1), .ctrl_data(ctrl_data_s1),
        .opa_addr(opa_addr_s1), .opb_addr(opb_addr_s1), .opa_data(opa_data_s1), .opb_data(opb_data_s1),
        .alu_a(alu_a_s1), .alu_b(alu_b_s1), .alu_op(alu_op_s1), .alu_result(alu_result_s1),
        .res_valid(res_valid_s1), .res_ready(res_ready_s1), .res_data(res_data_s1),
        .res_step(res_step_s1), .res_op(res_op_s1), .busy(busy_s1), .done(done_s1),
        .err_illegal(err_illegal_s1), .emit_count(emit_count_s1)
    );

    typedef struct {
        logic [4:0]  step;
        logic [3:0]  op;
        logic [31:0] data;
        int          cyc;
    } rec_t;

    typedef struct {
        string       name;
        int          step;
        logic [31:0] data;
    } vec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   done_cnt = 0, done_cyc = 0;
    int   hs_s1 = 0, done_cnt_s1 = 0, done_cyc_s1 = 0;
    logic [31:0] data_s1 = '0;

    always @(negedge clk) begin
        rec_t r;
        if (res_valid && res_ready) begin
            r.step = res_step; r.op = res_op; r.data = res_data; r.cyc = cyc;
            got_q.push_back(r);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (res_valid_s1 && res_ready_s1) begin
            hs_s1++;
            data_s1 = res_data_s1;
        end
        if (done_s1) begin
            done_cnt_s1++;
            done_cyc_s1 = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic load_base();
        for (int k = 0; k < 32; k++) ctrl_rom[k] = 6'h00;
        for (int k = 0; k < NS; k++) ctrl_rom[k] = {2'(k % 4), legal_ops[k % 7]};
        ctrl_rom[0]  = {2'd0, 4'd1};
        ctrl_rom[1]  = {2'd1, 4'd1};
        ctrl_rom[4]  = {2'd0, 4'd3};
        ctrl_rom[18] = {2'd2, 4'd10};
    endtask

    task automatic load_random();
        logic [3:0] op;
        for (int k = 0; k < NS; k++) begin
            if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(0, 15));
            else                           op = legal_ops[$urandom_range(0, 6)];
            ctrl_rom[k] = {2'($urandom_range(0, 3)), op};
        end
    endtask

    task automatic start_pulse(output int c0);
        got_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit rnd);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (rnd) res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_emit(input string tag, input int stp);
        bit seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (res_valid && res_step == 5'(stp)) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " emit_seen"}, 64'(seen), 64'd1);
    endtask

    // Reference: each legal step costs 4 cycles (+stall), each illegal one 1 cycle.
    task automatic compare_run(input string tag, input int c0, input bit timing,
                               input int stall_step, input int stall_len);
        int total = 0;
        bit exp_err = 1'b0;
        int n;
        exp_q.delete();
        for (int k = 0; k < NS; k++) begin
            logic [5:0] w;
            rec_t r;
            w = ctrl_rom[k];
            if (is_legal(w[3:0])) begin
                total += 4;
                if (k == stall_step) total += stall_len;
                r.step = 5'(k); r.op = w[3:0];
                r.data = alu_f(rom_a[w[5:4]], rom_b[w[5:4]], w[3:0]);
                r.cyc  = total;
                exp_q.push_back(r);
            end else begin
                total += 1;
                exp_err = 1'b1;
            end
        end
        check({tag, " result_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s result%0d", tag, i),
                  {23'd0, got_q[i].step, got_q[i].op, got_q[i].data},
                  {23'd0, exp_q[i].step, exp_q[i].op, exp_q[i].data});
            if (timing)
                check($sformatf("%s cycle%0d", tag, i), 64'(got_q[i].cyc - c0), 64'(exp_q[i].cyc));
        end
        check({tag, " emit_count"}, 64'(emit_count), 64'(exp_q.size()));
        check({tag, " err_illegal"}, 64'(err_illegal), 64'(exp_err));
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
        if (timing) check({tag, " done_cycle"}, 64'(done_cyc - c0), 64'(total + 1));
    endtask

    initial begin
        vec_t vecs[4];
        int   c0;
        rom_a = '{32'h77, 32'h95, 32'h107, 32'h21};
        rom_b = '{32'h77, 32'h95, 32'h103, 32'h22};
        legal_ops = '{4'd1, 4'd3, 4'd4, 4'd8, 4'd10, 4'd13, 4'd15};
        vecs[0] = '{"step0_add", 0, 32'hEE};
        vecs[1] = '{"step1_add", 1, 32'h12A};
        vecs[2] = '{"step4_sub", 4, 32'h0};
        vecs[3] = '{"step18_slt", 18, 32'h0};
        load_base();
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        start_s1 = 1'b0; res_ready_s1 = 1'b1;

        #1;
        check("reset_ctrl", {32'd0, ctrl_addr, opa_addr, opb_addr, alu_op, res_valid, res_step,
                             res_op, busy, done, err_illegal, emit_count}, 64'd0);
        check("reset_alu_ab", {alu_a, alu_b}, 64'd0);
        check("reset_res_data", 64'(res_data), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full run with constant ready, plus the spot-check table.
        start_pulse(c0);
        wait_done("full", 1'b0);
        compare_run("full", c0, 1'b1, -1, 0);
        for (int v = 0; v < 4; v++) begin
            logic [31:0] d = 32'hDEAD_BEEF;
            foreach (got_q[i]) if (got_q[i].step == 5'(vecs[v].step)) d = got_q[i].data;
            check(vecs[v].name, 64'(d), 64'(vecs[v].data));
        end

        // Random schedules, with random and with constant ready.
        for (int r = 0; r < 3; r++) begin
            load_random();
            start_pulse(c0);
            wait_done("rand", r != 2);
            compare_run($sformatf("rand%0d", r), c0, r == 2, -1, 0);
        end
        load_base();

        // Backpressure: step 1 held for 5 cycles.
        start_pulse(c0);
        wait_emit("bp", 1);
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp valid_held%0d", k), 64'(res_valid), 64'd1);
            check($sformatf("bp data_held%0d", k), {27'd0, res_step, res_data}, {27'd1, 32'h12A});
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        wait_done("bp", 1'b0);
        compare_run("bp", c0, 1'b1, 1, 5);

        // Illegal opcode at step 3.
        ctrl_rom[3] = 6'h00;
        start_pulse(c0);
        wait_done("illegal", 1'b0);
        compare_run("illegal", c0, 1'b1, -1, 0);
        check("illegal emit27", 64'(emit_count), 64'd27);
        if (got_q.size() > 3)
            check("illegal step_jump", {got_q[2].step, got_q[3].step}, {5'd2, 5'd4});
        else
            check("illegal step_jump_len", 64'(got_q.size()), 64'd27);
        load_base();

        // Abort while step 10 waits in EMIT.
        start_pulse(c0);
        wait_emit("abort", 10);
        res_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        res_ready = 1'b1;
        check("abort valid_busy", {res_valid, busy}, 64'd0);
        check("abort emit_count", 64'(emit_count), 64'd10);
        check("abort handshakes", 64'(got_q.size()), 64'd10);
        repeat (4) @(posedge clk);
        #1;
        check("abort no_done", 64'(done_cnt), 64'd0);
        start_pulse(c0);
        check("restart cleared", {busy, emit_count, ctrl_addr}, {1'b1, 6'd0, 5'd0});
        wait_done("restart", 1'b0);
        compare_run("restart", c0, 1'b1, -1, 0);

        // Asynchronous reset while step 2 sits in OPND.
        start_pulse(c0);
        wait_emit("arst", 1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("arst pre_busy", {busy, res_data}, {1'b1, 32'h12A});
        rst = 1'b1;
        #1;
        check("arst ctrl", {32'd0, ctrl_addr, opa_addr, opb_addr, alu_op, res_valid, res_step,
                            res_op, busy, done, err_illegal, emit_count}, 64'd0);
        check("arst alu_ab", {alu_a, alu_b}, 64'd0);
        check("arst res_data", 64'(res_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_pulse(c0);
        wait_done("fresh", 1'b0);
        compare_run("fresh", c0, 1'b1, -1, 0);

        // Single-step instance with a second start while busy.
        hs_s1 = 0; done_cnt_s1 = 0;
        @(posedge clk); #1;
        start_s1 = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start_s1 = 1'b0;
        @(posedge clk); #1;
        start_s1 = 1'b1;
        @(posedge clk); #1;
        start_s1 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("s1 results", 64'(hs_s1), 64'd1);
        check("s1 data", 64'(data_s1), 64'hEE);
        check("s1 done_pulses", 64'(done_cnt_s1), 64'd1);
        check("s1 done_cycle", 64'(done_cyc_s1 - c0), 64'd5);
        check("s1 idle_after", {busy_s1, emit_count_s1}, {1'b0, 6'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_step_sequencer.md
# alu_step_sequencer

Sequencer that drives the ALU through the stored opcode schedule. It walks the control ROM (6-bit words: operand-pair index plus ALU opcode) one step at a time. For each step it fetches an operand pair from the two 32-bit operand ROMs and presents registered operands and opcode to the ALU. It then captures the ALU result and emits it on a valid/ready stream toward the checker or display logic. ROMs and ALU are external and combinational; this block owns all sequencing, flow control and error flagging.

## Interface
Parameters:
- NUM_STEPS, 28: control-ROM entries walked per run (1..32).
- DATA_W, 32: operand/result width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next edge, any state.
- ctrl_addr  out  5  control ROM address.
- ctrl_data  in  6  control word: [5:4] operand index, [3:0] ALU opcode.
- opa_addr, opb_addr  out  2 each  operand ROM addresses (both driven with same index).
- opa_data, opb_data  in  DATA_W each  operand ROM data.
- alu_a, alu_b  out  DATA_W each  registered ALU operands.
- alu_op  out  4  registered ALU opcode.
- alu_result  in  DATA_W  combinational ALU result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_data  out  DATA_W  captured result.
- res_step  out  5  step index of res_data.
- res_op  out  4  opcode of res_data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at run completion.
- err_illegal  out  1  sticky: an illegal opcode was skipped this run.
- emit_count  out  6  results accepted this run.

## Operation
- Legal opcodes: 0001 add, 0011 sub, 0100 and, 1000 or, 1010 slt, 1101 complement A, 1111 nor. Every other value, including 0000 (ROM default), is illegal.
- States: IDLE, FETCH, OPND, EXEC, EMIT, DONE.
- IDLE: step=0. On start=1, clear err_illegal and emit_count, then go to FETCH.
- FETCH: ctrl_addr=step. Latch idx=ctrl_data[5:4] and op=ctrl_data[3:0].
  - Op legal: go to OPND.
  - Op illegal: set err_illegal. If step==NUM_STEPS-1 go to DONE; otherwise step+1 and stay in FETCH.
- OPND: opa_addr=opb_addr=idx. Register alu_a<=opa_data, alu_b<=opb_data, alu_op<=op. Go to EXEC.
- EXEC: register res_data<=alu_result, res_step<=step, res_op<=alu_op. Go to EMIT.
- EMIT: res_valid=1; res_data, res_step and res_op are held stable.
  - On res_valid&&res_ready: emit_count+1.
  - If step==NUM_STEPS-1 go to DONE; otherwise step+1 and go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- ctrl_addr, opa_addr and opb_addr are registered or derived from state registers only; they never depend on inputs combinationally.
- abort: highest priority below rst. Next state is IDLE; res_valid drops; done is not pulsed; err_illegal and emit_count hold until the next start.
- start while busy: ignored.

## Timing
- Reset values: all outputs 0 (alu_a, alu_b, alu_op, res_*, emit_count, err_illegal, busy, done, all addresses); state=IDLE.
- Cycles per legal step with res_ready held high: 4 (FETCH, OPND, EXEC, EMIT). Each stall cycle adds 1.
- Cycles per illegal step: 1.
- First res_valid: 4 cycles after the start edge, when step 0 is legal.
- done: asserted the cycle after the final handshake or final illegal FETCH.
- busy: rises the cycle after the start edge; falls with the DONE→IDLE transition.
- res_valid never drops without a handshake, except on abort or rst.
- Reset mid-run: immediate, asynchronous, to reset values.

## Test plan
- Bench models: operand A ROM {0x77, 0x95, 0x107, 0x21}; operand B ROM {0x77, 0x95, 0x103, 0x22}; behavioural ALU; the 28-entry opcode schedule.
- Full run, res_ready=1: 28 results emitted, 4 cycles apart. Step 0 (add, idx 0) gives res_data=0xEE. Step 4 (sub, idx 0) gives 0x0. Step 18 (slt, idx 2) gives 0x0. Final state: emit_count=28, one done pulse, err_illegal=0.
- Backpressure: res_ready low for 5 cycles at step 1. res_valid stays high and res_data=0x12A is stable; step 1 completes 5 cycles late; no result lost or duplicated.
- Illegal opcode: control entry 3 patched to 0x00. Step 3 is skipped, err_illegal=1, emit_count=27, res_step sequence jumps 2→4.
- Abort in EMIT at step 10: next cycle IDLE with res_valid=0 and busy=0, no done, emit_count=10. A new start restarts at step 0 and clears emit_count.
- Async rst asserted mid-OPND: all outputs 0 immediately, without waiting for a clk edge; start after release behaves as a fresh run.
- NUM_STEPS=1 with start pulsed again while busy: exactly one result; the second start is ignored; done 5 cycles after start.
